// File: rtl/nn_fixed_pkg.sv
// nn_fixed_pkg: Q5.10 sign-magnitude constants, neuron FSM states and sm->tc conversion
package nn_fixed_pkg;
  localparam int INT_W = 5;
  localparam int FRAC_W = 10;
  localparam int SM_W = 1 + INT_W + FRAC_W;
  localparam logic [SM_W-2:0] SM_MAX_MAG = 15'h7FFF;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BIAS, S_OUT} state_e;
  // Negative zero maps to 0 because -0 == 0 in two's complement.
  function automatic logic signed [SM_W:0] sm2tc(input logic [SM_W-1:0] p);
    logic signed [SM_W:0] mag;
    mag = {2'b00, p[SM_W-2:0]};
    return p[SM_W-1] ? -mag : mag;
  endfunction
endpackage

// File: rtl/neuron_accumulator_sm_sat_pack.sv
// sm_sat_pack: two's-complement sum -> saturated sign-magnitude Q5.10, optional ReLU
module sm_sat_pack
  import nn_fixed_pkg::*;
#(
  parameter int W       = 24,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [W-1:0]    sum,
  output logic        [SM_W-1:0] sm
);
  logic         neg;
  logic [W-1:0] mag;
  logic         ovf;
  always_comb begin
    neg = sum[W-1];
    mag = neg ? $unsigned(-sum) : $unsigned(sum);
    ovf = |mag[W-1:SM_W-1];
    sm  = (RELU_EN && neg) ? '0 : {neg, ovf ? SM_MAX_MAG : mag[SM_W-2:0]};
  end
endmodule

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sums bit-serial multiplier products per frame, adds bias, packs output
module neuron_accumulator
  import nn_fixed_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int ACC_WIDTH  = 24,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            start,
  input  logic [SM_W-1:0] product,
  input  logic [SM_W-1:0] bias,
  output logic [SM_W-1:0] result,
  output logic            result_valid,
  input  logic            result_ready,
  output logic            busy
);
  localparam int CW = $clog2(NUM_INPUTS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);
  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, bias_sum;
  logic        [3:0]           phase_q, phase_d;
  logic        [CW-1:0]        count_q, count_d;
  logic                        pend_q, pend_d, valid_q, valid_d, busy_q, busy_d;
  logic        [SM_W-1:0]      result_q, result_d, packed_sum;
  assign bias_sum = acc_q + ACC_WIDTH'(sm2tc(bias));
  sm_sat_pack #(.W(ACC_WIDTH), .RELU_EN(RELU_EN)) u_pack (
    .sum (bias_sum),
    .sm  (packed_sum)
  );
  // pend marks the cycle after a phase-15 enable, when the multiplier output is valid.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    phase_d  = phase_q;
    count_d  = count_q;
    pend_d   = pend_q;
    result_d = result_q;
    valid_d  = valid_q;
    if (start && state_q != S_OUT) begin
      state_d = S_ACCUM;
      acc_d   = '0;
      phase_d = '0;
      count_d = '0;
      pend_d  = 1'b0;
    end else if (state_q == S_ACCUM) begin
      phase_d = phase_q + 4'(enable);
      pend_d  = enable && phase_q == 4'hF;
      if (pend_q) begin
        acc_d   = acc_q + ACC_WIDTH'(sm2tc(product));
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = S_BIAS;
          phase_d = '0;
          pend_d  = 1'b0;
        end
      end
    end else if (state_q == S_BIAS) begin
      result_d = packed_sum;
      valid_d  = 1'b1;
      state_d  = S_OUT;
    end else if (state_q == S_OUT && result_ready) begin
      valid_d = 1'b0;
      state_d = S_IDLE;
    end
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      phase_q  <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end
  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator: directed scoreboard bench, ReLU and signed instances side by side
module tb_neuron_accumulator;
  logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, start = 1'b0, result_ready = 1'b0;
  logic [15:0] product = 16'h0, bias = 16'h0;
  logic [15:0] r1, r0;
  logic        v1, v0, b1, b0;
  int          n_cmp = 0, n_bad = 0;
  logic [15:0] q1[$], q0[$];
  logic [15:0] pv[4];
  int          gv[4];
  always #5 clk = ~clk;
  neuron_accumulator #(.NUM_INPUTS(4), .ACC_WIDTH(24), .RELU_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .product(product), .bias(bias),
    .result(r1), .result_valid(v1), .result_ready(result_ready), .busy(b1)
  );
  neuron_accumulator #(.NUM_INPUTS(4), .ACC_WIDTH(24), .RELU_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .product(product), .bias(bias),
    .result(r0), .result_valid(v0), .result_ready(result_ready), .busy(b0)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic int sm2int(input logic [15:0] p);
    return p[15] ? -int'(p[14:0]) : int'(p[14:0]);
  endfunction
  function automatic logic [15:0] pack(input int s, input bit relu);
    int m;
    if (s < 0 && relu) return 16'h0000;
    m = s < 0 ? -s : s;
    if (m > 32767) m = 32767;
    return m == 0 ? 16'h0000 : {s < 0, m[14:0]};
  endfunction
  task automatic run_neuron(input logic [15:0] b);
    int s;
    s = sm2int(b);
    for (int i = 0; i < 4; i++) s += sm2int(pv[i]);
    q1.push_back(pack(s, 1'b1));
    q0.push_back(pack(s, 1'b0));
    bias = b;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) begin
        enable = 1'b1;
        tick;
        if (i == 0) product = 16'($urandom);
      end
      product = pv[f];
      enable = 1'b0;
      for (int g = 0; g < gv[f]; g++) begin
        tick;
        product = 16'($urandom);
      end
    end
    tick;
    product = 16'($urandom);
  endtask
  task automatic get_result(input string tag);
    int t;
    logic [15:0] e1, e0;
    t = 0;
    while (!(v1 && v0) && t < 50) begin
      tick;
      t++;
    end
    e1 = q1.pop_front();
    e0 = q0.pop_front();
    check({tag, "_valid"}, {14'h0, v1, v0}, 16'h3);
    check({tag, "_relu"}, r1, e1);
    check({tag, "_signed"}, r0, e0);
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    check({tag, "_done"}, {12'h0, v1, v0, b1, b0}, 16'h0);
    check({tag, "_hold"}, r1, e1);
  endtask
  initial begin
    tick;
    tick;
    check("reset_result", {r1 | r0}, 16'h0);
    check("reset_flags", {12'h0, v1, v0, b1, b0}, 16'h0);
    reset = 1'b1;
    // 1: reset mid-accumulation while other inputs toggle
    start = 1'b1;
    tick;
    start = 1'b0;
    enable = 1'b1;
    repeat (20) tick;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enable = i[0];
      start = ~i[0];
      result_ready = i[1];
      tick;
      check("t1_result", {r1 | r0}, 16'h0);
      check("t1_flags", {12'h0, v1, v0, b1, b0}, 16'h0);
    end
    reset = 1'b1;
    enable = 1'b1;
    start = 1'b0;
    result_ready = 1'b0;
    repeat (3) tick;
    check("t1_idle_busy", {14'h0, b1, b0}, 16'h0);
    enable = 1'b0;
    // 2: basic sum and latency
    pv = '{16'h0400, 16'h0800, 16'h8400, 16'h0200};
    gv = '{0, 0, 0, 0};
    run_neuron(16'h0100);
    check("t2_lat_t2", {14'h0, v1, v0}, 16'h0);
    tick;
    check("t2_lat_t3", {14'h0, v1, v0}, 16'h3);
    check("t2_value", r0, 16'h0B00);
    get_result("t2");
    // 3: negative sums and negative zero
    pv = '{16'h8400, 16'h8400, 16'h8400, 16'h8400};
    gv = '{1, 0, 2, 1};
    run_neuron(16'h0000);
    get_result("t3_neg");
    check("t3_const", r0, 16'h9000);
    pv = '{16'h8000, 16'h8000, 16'h0400, 16'h8000};
    run_neuron(16'h8000);
    get_result("t3_nzero");
    // 4: saturation both signs
    pv = '{16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00};
    gv = '{0, 0, 0, 0};
    run_neuron(16'h7C00);
    get_result("t4_pos");
    check("t4_pos_const", r1, 16'h7FFF);
    pv = '{16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
    run_neuron(16'hFC00);
    get_result("t4_neg");
    check("t4_neg_const", r0, 16'hFFFF);
    // 5: backpressure with noisy inputs
    pv = '{16'h0400, 16'h0800, 16'h8400, 16'h0200};
    run_neuron(16'h8100);
    for (int t = 0; t < 50 && !(v1 && v0); t++) tick;
    for (int i = 0; i < 5; i++) begin
      enable = ~enable;
      start = i[0];
      product = 16'($urandom);
      tick;
      check("t5_stable_valid", {14'h0, v1, v0}, 16'h3);
      check("t5_stable_relu", r1, q1[0]);
      check("t5_stable_signed", r0, q0[0]);
    end
    enable = 1'b0;
    start = 1'b0;
    get_result("t5");
    // 6: restart after two products, then gapped frames
    pv = '{16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00};
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int f = 0; f < 3; f++) begin
      enable = 1'b1;
      repeat (16) tick;
      product = 16'h7C00;
      enable = 1'b0;
      if (f < 2) tick;
    end
    pv = '{16'h0400, 16'h0800, 16'h8400, 16'h0200};
    gv = '{0, 1, 2, 3};
    run_neuron(16'h0100);
    get_result("t6");
    check("t6_const", r1, 16'h0B00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
